// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and window helper for vga_timing_gen and the maze display controller.
// The origin is the start of the sync pulse: sync, back porch, visible, front porch.
package vga_timing_pkg;

    localparam int COUNT_W   = 10;

    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;

    localparam int H_TOTAL   = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL   = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    localparam int H_VIS_START = H_SYNC + H_BACK;
    localparam int H_VIS_END   = H_VIS_START + H_VISIBLE;
    localparam int V_VIS_START = V_SYNC + V_BACK;
    localparam int V_VIS_END   = V_VIS_START + V_VISIBLE;

    // Bounds are one bit wider than the counter so an end bound of 1024 still compares correctly.
    function automatic logic in_range(input logic [COUNT_W-1:0] x,
                                      input logic [COUNT_W:0]   lo,
                                      input logic [COUNT_W:0]   hi);
        return ({1'b0, x} >= lo) && ({1'b0, x} < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to the pixel rate: registered tick is high on the clk where
// the divider sits at CLK_DIV-1, so CLK_DIV=1 holds tick high once out of reset.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pixel_tick_div: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= div_next;
            tick <= (div_next == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate counters plus registered hSync/vSync/bright/frame_start.
// Optional frame counter output frame_cnt is enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int CLK_DIV   = 4,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
);
`else
);
`endif

    localparam int H_TOT = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOT = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_size
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
    localparam logic [10:0] H_VIS_LO = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_VIS_HI = 11'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [10:0] V_VIS_LO = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_VIS_HI = 11'(V_SYNC + V_BACK + V_VISIBLE);

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       frame_wrap;

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (pixel_en)
    );

    always_comb begin
        h_next     = hCount;
        v_next     = vCount;
        frame_wrap = 1'b0;
        if (pixel_en) begin
            if (hCount == H_LAST) begin
                h_next = '0;
                if (vCount == V_LAST) begin
                    v_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_next = vCount + 10'd1;
                end
            end else begin
                h_next = hCount + 10'd1;
            end
        end
    end

    // Decodes use the next counter values so they land in the same cycle as the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hCount      <= h_next;
            vCount      <= v_next;
            hSync       <= !({1'b0, h_next} < H_SYNC_W);
            vSync       <= !({1'b0, v_next} < V_SYNC_W);
            bright      <= in_range(h_next, H_VIS_LO, H_VIS_HI) &&
                           in_range(v_next, V_VIS_LO, V_VIS_HI);
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance for divider/line timing and a tiny-raster
// instance (CLK_DIV=1) for window edges, whole frames and randomized resets.
module tb_vga_timing_gen;

    typedef struct packed {
        int d; int hs; int hb; int hv; int hf; int vs; int vb; int vv; int vf;
    } cfg_t;

    // Pixel-tick view of the raster: p ticks since reset, k clks since reset.
    typedef struct packed {
        int k; int p; bit pe; bit fs; int fc;
    } mdl_t;

    typedef struct {
        int h; int v; bit hs; bit vs; bit br;
    } vec_t;

    localparam cfg_t CFG_A = '{4, 96, 48, 640, 16, 2, 33, 480, 10};
    localparam cfg_t CFG_B = '{1, 3, 2, 5, 2, 2, 2, 3, 1};

    logic clk = 1'b0;
    logic rstA_n = 1'b0;
    logic rstB_n = 1'b0;
    bit   runChecks = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;

    logic       peA, hsA, vsA, brA, fsA;
    logic [9:0] hA, vA;
    logic       peB, hsB, vsB, brB, fsB;
    logic [9:0] hB, vB;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fcA, fcB;
`endif

    mdl_t mA = '0;
    mdl_t mB = '0;

    always #5 clk = ~clk;

    vga_timing_gen dutA (
        .clk(clk), .rst_n(rstA_n), .pixel_en(peA), .hCount(hA), .vCount(vA),
        .hSync(hsA), .vSync(vsA), .bright(brA), .frame_start(fsA)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fcA)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(3), .H_BACK(2), .H_VISIBLE(5), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_VISIBLE(3), .V_FRONT(1)
    ) dutB (
        .clk(clk), .rst_n(rstB_n), .pixel_en(peB), .hCount(hB), .vCount(vB),
        .hSync(hsB), .vSync(vsB), .bright(brB), .frame_start(fsB)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fcB)
`endif
    );

    wire [24:0] outsA = {peA, hA, vA, hsA, vsA, brA, fsA};
    wire [24:0] outsB = {peB, hB, vB, hsB, vsB, brB, fsB};

    function automatic mdl_t modelEdge(cfg_t c, mdl_t m);
        mdl_t n = m;
        int frame = (c.hs + c.hb + c.hv + c.hf) * (c.vs + c.vb + c.vv + c.vf);
        n.fs = 1'b0;
        if (m.pe) begin
            n.p = m.p + 1;
            if (n.p % frame == 0) begin
                n.fs = 1'b1;
                n.fc = (m.fc + 1) % 65536;
            end
        end
        n.k  = m.k + 1;
        n.pe = (n.k % c.d) == (c.d - 1);
        return n;
    endfunction

    function automatic logic [24:0] expOut(cfg_t c, mdl_t m);
        int ht = c.hs + c.hb + c.hv + c.hf;
        int vt = c.vs + c.vb + c.vv + c.vf;
        int h  = m.p % ht;
        int v  = (m.p / ht) % vt;
        bit hs = h >= c.hs;
        bit vs = v >= c.vs;
        bit br = (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.hv) &&
                 (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.vv);
        return {m.pe, 10'(h), 10'(v), hs, vs, br, m.fs};
    endfunction

    always @(posedge clk or negedge rstA_n) begin
        if (!rstA_n) mA = '0;
        else         mA = modelEdge(CFG_A, mA);
    end

    always @(posedge clk or negedge rstB_n) begin
        if (!rstB_n) mB = '0;
        else         mB = modelEdge(CFG_B, mB);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (runChecks) begin
            checkOutput("A_model", 32'(outsA), 32'(expOut(CFG_A, mA)));
            checkOutput("B_model", 32'(outsB), 32'(expOut(CFG_B, mB)));
`ifdef VGA_FRAME_CNT_EN
            checkOutput("A_frame_cnt_model", 32'(fcA), 32'(16'(mA.fc)));
            checkOutput("B_frame_cnt_model", 32'(fcB), 32'(16'(mB.fc)));
`endif
        end
    end

    task automatic waitPos(input bit onB, input int h, input int v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (onB ? (hB == 10'(h) && vB == 10'(v)) : (hA == 10'(h) && vA == 10'(v))) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput($sformatf("reach_%s_%0d_%0d", onB ? "B" : "A", h, v), 32'(ok), 32'd1);
    endtask

    task automatic waitFrameB(input int budget, output int cycles);
        bit ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (fsB) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("B_frame_start_seen", 32'(ok), 32'd1);
    endtask

    // Random-length run on dutB, then an async reset landing mid-cycle, held for a few clks.
    task automatic applyStimulus(input int cycles, input int phase, input int hold);
        repeat (cycles) @(posedge clk);
        #(phase);
        rstB_n = 1'b0;
        #1;
        checkOutput("B_async_reset", 32'(outsB), 32'd0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rstB_n = 1'b1;
    endtask

    vec_t vecs[9];

    initial begin
        bit ok;
        int edges;
        int cycles;

        vecs[0] = '{4, 4, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{5, 4, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{9, 6, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{10, 6, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{7, 7, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{7, 3, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{2, 0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3, 1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{11, 2, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        checkOutput("A_reset_state", 32'(outsA), 32'd0);
        checkOutput("B_reset_state", 32'(outsB), 32'd0);
        runChecks = 1'b1;
        rstA_n = 1'b1;
        rstB_n = 1'b1;

        // Divider start-up and steady period on the default instance.
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            edges++;
            if (peA) break;
        end
        checkOutput("A_first_pixel_en_edges", 32'(edges), 32'd3);
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            edges++;
            if (peA) break;
        end
        checkOutput("A_pixel_en_period", 32'(edges), 32'd4);

        waitPos(1'b0, 95, 0, 2000, ok);
        checkOutput("A_hsync_at_95", 32'(hsA), 32'd0);
        waitPos(1'b0, 96, 0, 20, ok);
        checkOutput("A_hsync_at_96", 32'(hsA), 32'd1);
        waitPos(1'b0, 799, 0, 4000, ok);
        checkOutput("A_hsync_at_799", 32'(hsA), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hA != 10'd799) break;
        end
        checkOutput("A_line_wrap_pos", 32'({hA, vA}), 32'({10'd0, 10'd1}));
        checkOutput("A_line_wrap_sync", 32'({hsA, vsA, brA}), 32'd0);

        // Mid-frame asynchronous reset on the default instance.
        waitPos(1'b0, 500, 1, 4000, ok);
        @(posedge clk);
        #2;
        rstA_n = 1'b0;
        #1;
        checkOutput("A_async_reset", 32'(outsA), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstA_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            edges++;
            if (hA == 10'd1) break;
        end
        checkOutput("A_restart_first_step", 32'(edges), 32'd4);
        checkOutput("A_restart_line", 32'(vA), 32'd0);

        // Window and sync edges on the tiny raster.
        for (int i = 0; i < 9; i++) begin
            waitPos(1'b1, vecs[i].h, vecs[i].v, 250, ok);
            checkOutput($sformatf("B_vec%0d", i), 32'({hsB, vsB, brB}),
                        32'({vecs[i].hs, vecs[i].vs, vecs[i].br}));
        end

        // Whole frames: one frame_start per 96 pixel ticks, landing just after (11,7)->(0,0).
        applyStimulus(1, 2, 1);
`ifdef VGA_FRAME_CNT_EN
        checkOutput("B_frame_cnt_reset", 32'(fcB), 32'd0);
`endif
        waitFrameB(200, cycles);
        checkOutput("B_frame_start_pos", 32'({hB, vB}), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        checkOutput("B_frame_cnt_1", 32'(fcB), 32'd1);
`endif
        for (int f = 2; f <= 3; f++) begin
            waitFrameB(200, cycles);
            checkOutput($sformatf("B_frame_interval_%0d", f), 32'(cycles), 32'd96);
`ifdef VGA_FRAME_CNT_EN
            checkOutput($sformatf("B_frame_cnt_%0d", f), 32'(fcB), 32'(f));
`endif
        end

        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom_range(5, 250), $urandom_range(1, 3), $urandom_range(1, 3));
        end
        repeat (120) @(negedge clk);

        runChecks = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
